// File: rtl/fb_writer.sv
// Frame-buffer writer: stores an accepted pixel stream at raster addresses y*H_RES+x using an incremental counter.
// Optional macro FB_WRITER_CONTINUOUS_EN: frames are written back to back without returning to IDLE.
module fb_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              pixel_in_valido,
  output logic              pixel_in_pronto,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_count
);

  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic [7:0]          frame_count_q, frame_count_d;
  logic                accept_s;
  logic                line_end_s;
  logic                frame_end_s;

  // Ready is gated by abort so a pixel offered in the abort cycle is never written.
  assign pixel_in_pronto = (state_q == S_WRITE) && !abort;
  assign accept_s        = pixel_in_valido && pixel_in_pronto;
  assign line_end_s      = (x_q == X_W'(H_RES - 1));
  assign frame_end_s     = line_end_s && (y_q == Y_W'(V_RES - 1));

  assign busy        = (state_q != S_IDLE);
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign done        = done_q;
  assign frame_count = frame_count_q;

  // Next-state, raster counters and registered write port.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_WRITE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = pixel_in;
          addr_d    = addr_q + ADDR_W'(1);
          if (line_end_s) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
          if (frame_end_s) begin
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
`ifdef FB_WRITER_CONTINUOUS_EN
            state_d = S_WRITE;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      done_q        <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      addr_q        <= addr_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule
